// File: rtl/clock_ctrl_pkg.sv
// Shared types and limits for the clock-setting controller.
// Edit values are kept in range by the helpers here.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SET_H  = 2'd1,
    ST_SET_M  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  localparam logic [4:0] MAX_H = 5'd23;
  localparam logic [5:0] MAX_M = 6'd59;

  function automatic logic [4:0] inc_h(input logic [4:0] h);
    return (h >= MAX_H) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [5:0] inc_m(input logic [5:0] m);
    return (m >= MAX_M) ? 6'd0 : m + 6'd1;
  endfunction

  // An out-of-range clock value entering edit mode starts from zero.
  function automatic logic [4:0] fit_h(input logic [4:0] h);
    return (h > MAX_H) ? 5'd0 : h;
  endfunction

  function automatic logic [5:0] fit_m(input logic [5:0] m);
    return (m > MAX_M) ? 6'd0 : m;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer, stability filter and press detector for one
// active-low pushbutton. press is a single-cycle pulse per debounced press.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 500000
) (
  input  logic clk_50,
  input  logic clr,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_50 or negedge clr) begin
    if (!clr) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // cnt counts consecutive cycles the synchronized key disagrees with level.
  always_ff @(posedge clk_50 or negedge clr) begin
    if (!clr) begin
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Two-button time-setting controller: mode steps RUN -> hours -> minutes ->
// commit, inc bumps the field being edited, which blinks while selected.
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned BLINK_CYC    = 12500000,
  parameter int unsigned TIMEOUT_CYC  = 500000000
) (
  input  logic       clk_50,
  input  logic       clr,
  input  logic       key_mode_n,
  input  logic       key_inc_n,
  input  logic [4:0] cur_h,
  input  logic [5:0] cur_m,
  output logic [4:0] set_h,
  output logic [5:0] set_m,
  output logic       load,
  output logic       blank_h,
  output logic       blank_m,
  output logic       editing
);

  localparam int unsigned BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

  state_t        state;
  state_t        state_nxt;
  logic          mode_press;
  logic          inc_press;
  logic [4:0]    edit_h;
  logic [5:0]    edit_m;
  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic [TW-1:0] idle_cnt;
  logic          idle_done;
  logic          state_chg;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode (
    .clk_50 (clk_50),
    .clr    (clr),
    .key_n  (key_mode_n),
    .press  (mode_press)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_inc (
    .clk_50 (clk_50),
    .clr    (clr),
    .key_n  (key_inc_n),
    .press  (inc_press)
  );

  assign idle_done = (idle_cnt == TIMEOUT_LAST);
  assign state_chg = (state_nxt != state);

  always_ff @(posedge clk_50 or negedge clr) begin
    if (!clr) state <= ST_RUN;
    else      state <= state_nxt;
  end

  // Mode has priority over inc; a press in the timeout cycle keeps the edit.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (mode_press) state_nxt = ST_SET_H;
      ST_SET_H: begin
        if (mode_press)                   state_nxt = ST_SET_M;
        else if (!inc_press && idle_done) state_nxt = ST_RUN;
      end
      ST_SET_M: begin
        if (mode_press)                   state_nxt = ST_COMMIT;
        else if (!inc_press && idle_done) state_nxt = ST_RUN;
      end
      ST_COMMIT: state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    editing = 1'b0;
    load    = 1'b0;
    blank_h = 1'b0;
    blank_m = 1'b0;
    case (state)
      ST_SET_H: begin
        editing = 1'b1;
        blank_h = phase;
      end
      ST_SET_M: begin
        editing = 1'b1;
        blank_m = phase;
      end
      ST_COMMIT: load = 1'b1;
      default: ;
    endcase
  end

  assign set_h = edit_h;
  assign set_m = edit_m;

  always_ff @(posedge clk_50 or negedge clr) begin
    if (!clr) begin
      edit_h <= '0;
      edit_m <= '0;
    end else begin
      case (state)
        ST_RUN: if (mode_press) begin
          edit_h <= fit_h(cur_h);
          edit_m <= fit_m(cur_m);
        end
        ST_SET_H: if (!mode_press && inc_press) edit_h <= inc_h(edit_h);
        ST_SET_M: if (!mode_press && inc_press) edit_m <= inc_m(edit_m);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_50 or negedge clr) begin
    if (!clr) begin
      idle_cnt <= '0;
    end else if (!editing || state_chg || mode_press || inc_press) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

  // Phase restarts visible on every state change and every inc press.
  always_ff @(posedge clk_50 or negedge clr) begin
    if (!clr) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (!editing || state_chg || inc_press) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios plus random key traffic,
// all outputs compared every cycle against a behavioural model.
module tb_clock_set_ctrl;
  import clock_ctrl_pkg::*;

  localparam int DEB   = 4;
  localparam int BLINK = 8;
  localparam int TO    = 200;

  logic       clk_50     = 1'b0;
  logic       clr        = 1'b0;
  logic       key_mode_n = 1'b1;
  logic       key_inc_n  = 1'b1;
  logic [4:0] cur_h      = '0;
  logic [5:0] cur_m      = '0;
  logic [4:0] set_h;
  logic [5:0] set_m;
  logic       load;
  logic       blank_h;
  logic       blank_m;
  logic       editing;

  always #10 clk_50 = ~clk_50;

  clock_set_ctrl #(
    .DEBOUNCE_CYC (DEB),
    .BLINK_CYC    (BLINK),
    .TIMEOUT_CYC  (TO)
  ) dut (
    .clk_50     (clk_50),
    .clr        (clr),
    .key_mode_n (key_mode_n),
    .key_inc_n  (key_inc_n),
    .cur_h      (cur_h),
    .cur_m      (cur_m),
    .set_h      (set_h),
    .set_m      (set_m),
    .load       (load),
    .blank_h    (blank_h),
    .blank_m    (blank_m),
    .editing    (editing)
  );

  int   n_checks   = 0;
  int   n_fail     = 0;
  bit   chk_on     = 1'b0;
  int   load_cnt   = 0;
  int   edit_rises = 0;
  int   ld_h       = 0;
  int   ld_m       = 0;
  logic edit_q     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_RUN, M_HOURS, M_MINUTES, M_COMMIT} mstep_t;
  mstep_t m_st      = M_RUN;
  int     m_h       = 0;
  int     m_m       = 0;
  int     cyc       = 0;
  int     last_evt  = 0;
  int     blink_ref = 0;
  bit     m_press [2];
  bit     m_lvl   [2];
  bit     hist    [2][8];

  task automatic model_reset();
    m_st = M_RUN;
    m_h = 0;
    m_m = 0;
    for (int k = 0; k < 2; k++) begin
      m_press[k] = 1'b0;
      m_lvl[k]   = 1'b1;
      for (int i = 0; i < 8; i++) hist[k][i] = 1'b1;
    end
  endtask

  task automatic model_step();
    mstep_t prev;
    bit     raw [2];
    bit     flip;
    cyc++;
    prev = m_st;
    case (m_st)
      M_RUN: if (m_press[0]) begin
        m_st = M_HOURS;
        m_h  = (int'(cur_h) > 23) ? 0 : int'(cur_h);
        m_m  = (int'(cur_m) > 59) ? 0 : int'(cur_m);
      end
      M_HOURS: begin
        if (m_press[0])                m_st = M_MINUTES;
        else if (m_press[1])           m_h = (m_h + 1) % 24;
        else if (cyc - last_evt >= TO) m_st = M_RUN;
      end
      M_MINUTES: begin
        if (m_press[0])                m_st = M_COMMIT;
        else if (m_press[1])           m_m = (m_m + 1) % 60;
        else if (cyc - last_evt >= TO) m_st = M_RUN;
      end
      default: m_st = M_RUN;
    endcase
    if (m_press[0] || m_press[1]) last_evt = cyc;
    if (m_st != prev || (m_press[1] && (prev == M_HOURS || prev == M_MINUTES)))
      blink_ref = cyc;
    raw[0] = key_mode_n;
    raw[1] = key_inc_n;
    // Synchronized value is the raw sample two edges old; a new level is
    // accepted once the last DEB synchronized samples all disagree with it.
    for (int k = 0; k < 2; k++) begin
      for (int i = 7; i > 0; i--) hist[k][i] = hist[k][i-1];
      hist[k][0] = raw[k];
      flip = 1'b1;
      for (int i = 2; i < DEB + 2; i++) if (hist[k][i] == m_lvl[k]) flip = 1'b0;
      if (flip) m_lvl[k] = ~m_lvl[k];
      m_press[k] = flip && !m_lvl[k];
    end
  endtask

  function automatic logic [14:0] model_vec();
    bit ph;
    ph = (((cyc - blink_ref) / BLINK) % 2) == 1;
    return {5'(m_h), 6'(m_m), m_st == M_COMMIT, m_st == M_HOURS && ph,
            m_st == M_MINUTES && ph, m_st == M_HOURS || m_st == M_MINUTES};
  endfunction

  always @(posedge clk_50) begin
    if (!clr) model_reset();
    else      model_step();
  end

  // ---------------- compare and monitors ----------------
  always @(negedge clk_50) begin
    if (chk_on)
      check("outputs", 32'({set_h, set_m, load, blank_h, blank_m, editing}),
            clr ? 32'(model_vec()) : 32'd0);
    if (clr && load) begin
      load_cnt++;
      ld_h = int'(set_h);
      ld_m = int'(set_m);
    end
    if (editing && !edit_q) edit_rises++;
    edit_q = editing;
  end

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic drive(input logic mode_n, input logic inc_n);
    #2;
    key_mode_n = mode_n;
    key_inc_n  = inc_n;
  endtask

  task automatic press(input bit pm, input bit pi);
    drive(!pm, !pi);
    tick(8);
    drive(1'b1, 1'b1);
    tick(8);
  endtask

  initial begin
    int n;
    int r;
    int hold;
    int gap;

    tick(2);
    chk_on = 1'b1;
    tick(1);
    check("reset_outputs", 32'({set_h, set_m, load, blank_h, blank_m, editing}), 32'd0);
    check("reset_state", 32'(dut.state), 32'(ST_RUN));
    #2 clr = 1'b1;
    cur_h = 5'd7;
    cur_m = 6'd33;
    tick(4);

    // Bouncing mode key: one press, hours edit loaded from the clock.
    drive(1'b0, 1'b1); tick(2);
    drive(1'b1, 1'b1); tick(2);
    drive(1'b0, 1'b1); tick(12);
    drive(1'b1, 1'b1); tick(10);
    check("bounce_one_entry", 32'(edit_rises), 32'd1);
    check("bounce_state", 32'(dut.state), 32'(ST_SET_H));
    check("copy_h", 32'(set_h), 32'd7);
    check("copy_m", 32'(set_m), 32'd33);

    // Blink: wait for a fresh rise of blank_h, then an inc press forces it off.
    n = 0;
    while (blank_h && n < 20) begin tick(1); n++; end
    while (!blank_h && n < 40) begin tick(1); n++; end
    check("blank_h_rises", 32'(blank_h), 32'd1);
    drive(1'b1, 1'b0);
    n = 0;
    while (set_h == 5'd7 && n < 14) begin tick(1); n++; end
    check("inc_applied", 32'(set_h), 32'd8);
    check("inc_blank_h", 32'(blank_h), 32'd0);
    for (int j = 1; j <= 20; j++) begin
      tick(1);
      check("blink_h", 32'(blank_h), (j >= 8 && j < 16) ? 32'd1 : 32'd0);
      check("blink_m", 32'(blank_m), 32'd0);
    end
    drive(1'b1, 1'b1);
    tick(10);

    // Mode and inc together in hours: minutes entered, hours untouched.
    drive(1'b0, 1'b0);
    n = 0;
    while (dut.state != ST_SET_M && n < 14) begin tick(1); n++; end
    check("both_state", 32'(dut.state), 32'(ST_SET_M));
    check("both_hours", 32'(set_h), 32'd8);
    drive(1'b1, 1'b1);

    // No press in minutes: abandon after the timeout without a load.
    n = 0;
    while (editing && n < 260) begin tick(1); n++; end
    check("timeout_len", 32'(n), 32'd200);
    check("timeout_editing", 32'(editing), 32'd0);
    check("timeout_state", 32'(dut.state), 32'(ST_RUN));
    check("timeout_no_load", 32'(load_cnt), 32'd0);
    tick(4);

    // Full edit with wraps: 22:58 -> 23,0,1 and 59,0.
    cur_h = 5'd22;
    cur_m = 6'd58;
    press(1'b1, 1'b0);
    repeat (3) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    repeat (2) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    tick(4);
    check("commit_loads", 32'(load_cnt), 32'd1);
    check("commit_h", 32'(ld_h), 32'd1);
    check("commit_m", 32'(ld_m), 32'd0);
    check("commit_state", 32'(dut.state), 32'(ST_RUN));

    // Reset in the middle of a minutes edit.
    cur_h = 5'd3;
    cur_m = 6'd4;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("pre_clr_state", 32'(dut.state), 32'(ST_SET_M));
    #3 clr = 1'b0;
    #1;
    check("clr_outputs", 32'({set_h, set_m, load, blank_h, blank_m, editing}), 32'd0);
    check("clr_state", 32'(dut.state), 32'(ST_RUN));
    tick(3);
    #2 clr = 1'b1;
    tick(30);
    check("clr_no_load", 32'(load_cnt), 32'd1);

    // Random key traffic with bounces, long idles and reset pulses.
    for (int t = 0; t < 160; t++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        #3 clr = 1'b0;
        tick(2);
        #2 clr = 1'b1;
        tick(2);
      end else begin
        hold = int'($urandom_range(1, 12));
        gap  = (r == 1) ? int'($urandom_range(150, 260)) : int'($urandom_range(1, 14));
        drive(!((r < 10) || (r >= 17)), !(r >= 10));
        cur_h = 5'($urandom_range(0, 23));
        cur_m = 6'($urandom_range(0, 59));
        tick(hold);
        drive(1'b1, 1'b1);
        tick(gap);
      end
    end
    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 500000, meaning clk_50 cycles a key must be stable (10 ms).
REQ-002 SHALL have parameter BLINK_CYC, default 12500000, meaning the half-period of the edit-field blink (250 ms).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 500000000, meaning idle cycles before an edit is abandoned (10 s).
REQ-004 SHALL have port clk_50  input  1  system clock, 50 MHz.
REQ-005 SHALL have port clr  input  1  reset: asynchronous, active-low.
REQ-006 SHALL have port key_mode_n  input  1  raw mode pushbutton, active-low, asynchronous to clk_50.
REQ-007 SHALL have port key_inc_n  input  1  raw increment pushbutton, active-low, asynchronous to clk_50.
REQ-008 SHALL have port cur_h  input  5  current clock hours, 0..23.
REQ-009 SHALL have port cur_m  input  6  current clock minutes, 0..59.
REQ-010 SHALL have port set_h  output  5  hours value offered to the clock load port.
REQ-011 SHALL have port set_m  output  6  minutes value offered to the clock load port.
REQ-012 SHALL have port load  output  1  one-cycle strobe committing set_h/set_m to the clock.
REQ-013 SHALL have port blank_h  output  1  1 = blank the hour digits.
REQ-014 SHALL have port blank_m  output  1  1 = blank the minute digits.
REQ-015 SHALL have port editing  output  1  1 while in SET_H or SET_M.

Function
REQ-016 SHALL pass each key through a 2-FF synchronizer and accept a new level only after it has been stable for DEBOUNCE_CYC consecutive cycles.
REQ-017 SHALL generate one 1-cycle press pulse per debounced high-to-low transition; holding a key SHALL NOT repeat.
REQ-018 SHALL implement FSM states RUN, SET_H, SET_M and COMMIT.
REQ-019 SHALL transition RUN->SET_H on a mode press and copy cur_h/cur_m into the edit registers in that cycle.
REQ-020 SHALL transition SET_H->SET_M and SET_M->COMMIT on a mode press; COMMIT->RUN SHALL occur unconditionally after one cycle.
REQ-021 SHALL increment the hour edit register by 1 on an inc press in SET_H, wrapping 23->0.
REQ-022 SHALL increment the minute edit register by 1 on an inc press in SET_M, wrapping 59->0.
REQ-023 SHALL ignore inc presses in RUN and COMMIT.
REQ-024 SHALL let a mode press take priority over a simultaneous inc press; in that case the edit register is not incremented.
REQ-025 SHALL drive load=1 only in COMMIT, for exactly one cycle, with set_h/set_m holding the edited values; the edited values SHALL always be within range.
REQ-026 SHALL drive set_h/set_m from the edit registers at all times, with load=0 outside COMMIT.
REQ-027 SHALL toggle a blink phase every BLINK_CYC cycles while editing, and reset the phase to 0 (visible) on every state entry and every inc press.
REQ-028 SHALL drive blank_h=phase in SET_H and blank_m=phase in SET_M; both blanks SHALL be 0 in every other case.
REQ-029 SHALL return SET_H/SET_M->RUN without a load after TIMEOUT_CYC cycles with no press; any press SHALL restart the timeout count.

Reset
REQ-030 SHALL, while clr=0, force state RUN, set_h=0, set_m=0, load=0, blank_h=0, blank_m=0, editing=0, all counters to 0, and debounced key levels to 1 (released).
REQ-031 SHALL, if reset occurs during SET_H, SET_M or COMMIT, abandon the edit with no load pulse either during or after reset.

Structure
REQ-032 SHALL take the state enum, MAX_H=23 and MAX_M=59 from the shared package clock_ctrl_pkg.
REQ-033 SHALL implement synchronization, debounce and edge detection in sub-module key_debounce, instantiated once per key.

Verification (DEBOUNCE_CYC=4, BLINK_CYC=8, TIMEOUT_CYC=200)
REQ-034 SHALL check: key_mode_n bounces 1-0-1-0 at 2-cycle spacing, then stays 0 -> exactly one press, and RUN->SET_H with edit registers = cur_h/cur_m.
REQ-035 SHALL check: from cur_h=22, cur_m=58, sequence mode, inc x3, mode, inc x2, mode -> single load pulse with set_h=1, set_m=0.
REQ-036 SHALL check: in SET_H, hold for 20 cycles -> blank_h toggles every 8 cycles, blank_m stays 0; an inc press forces blank_h=0.
REQ-037 SHALL check: in SET_M, no press for 200 cycles -> return to RUN, load never asserted, editing=0.
REQ-038 SHALL check: mode and inc pressed in the same cycle in SET_H -> enter SET_M with hours unchanged.
REQ-039 SHALL check: clr pulsed low in SET_M -> outputs take reset values immediately, state RUN, and no load pulse afterwards.
